// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract unit built around a DIGIT-bit
// ripple slice. Operands shift right one slice per cycle; the result shifts in
// from the MSB side, and the carry is held in a register between slices.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NumSlices = WIDTH / DIGIT;
  localparam int unsigned CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  // Reject slice widths that do not tile the operand.
  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last_slice;
  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             msb_cin;
  logic [WIDTH-1:0] slice_ext;

  // Start is only honoured outside RUN, so DONE supports back-to-back issue.
  assign accept     = start && (state_q != StRun);
  assign last_slice = (cnt_q == CntW'(NumSlices - 1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_slice) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Ripple the low DIGIT bits of A, B and the held carry; the carry entering
  // the top bit of the slice is kept for overflow on the final slice.
  always_comb begin
    logic cv;
    cv        = carry_q;
    msb_cin   = 1'b0;
    slice_sum = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      msb_cin      = cv;
      slice_sum[i] = a_q[i] ^ b_q[i] ^ cv;
      cv           = (a_q[i] & b_q[i]) | (cv & (a_q[i] ^ b_q[i]));
    end
    slice_cout = cv;
  end

  // Datapath next-state: capture on accept, shift one slice per RUN cycle,
  // publish the result only on the last slice.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    slice_ext = '0;
    slice_ext[DIGIT-1:0] = slice_sum;
    if (state_q == StRun) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      acc_d   = (acc_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
      carry_d = slice_cout;
      cnt_d   = cnt_q + CntW'(1);
      if (last_slice) begin
        sum_d  = (acc_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
        cout_d = slice_cout;
        ovf_d  = msb_cin ^ slice_cout;
      end
    end else if (accept) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      acc_d   = '0;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
    end
  end

  // Datapath registers; reset clears everything, including an in-flight op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
